// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Request/response memory with programmable wait states and a
//            side program port for preloading storage.
// Revision : 1.0 - initial release
// ============================================================================

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  logic w_accept;
  logic w_commit;

  assign req_ready = (r_state == S_IDLE) && !prog_we && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rw    <= req_rw;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= c_wait;
            busy    <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_commit) begin
            // Read samples the pre-edge array, so a same-edge prog write is not seen.
            rsp_rdata <= r_rw ? r_wdata : r_mem[r_addr];
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Program port is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (w_commit && r_rw) begin
      r_mem[r_addr] <= r_wdata;
    end
    if (prog_we) begin
      r_mem[prog_addr] <= prog_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder (WAIT=2 and WAIT=0).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rw, rsp_ready, prog_we;
  logic        req_ready, rsp_valid, busy;
  logic [7:0]  req_addr, prog_addr;
  logic [15:0] req_wdata, prog_wdata, rsp_rdata;

  logic        req_valid0, req_rw0, rsp_ready0, prog_we0;
  logic        req_ready0, rsp_valid0, busy0;
  logic [7:0]  req_addr0, prog_addr0;
  logic [15:0] req_wdata0, prog_wdata0, rsp_rdata0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .busy(busy)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_rw(req_rw0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .prog_we(prog_we0), .prog_addr(prog_addr0), .prog_wdata(prog_wdata0),
    .busy(busy0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick;
    prog_we = 1'b0;
  endtask

  // Full transaction on the WAIT=2 instance with a bounded wait for rsp_valid.
  task automatic xact(input logic rw, input logic [7:0] a, input logic [15:0] d,
                      output logic [15:0] data);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) tick;
    chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    data = rsp_rdata;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    prog_we = 0; prog_addr = 0; prog_wdata = 0;
    req_valid0 = 0; req_rw0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;
    prog_we0 = 0; prog_addr0 = 0; prog_wdata0 = 0;
    tick; tick;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata",     {16'd0, rsp_rdata}, 32'h0000);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Program write blocks acceptance while strobed
    prog_we = 1'b1; prog_addr = 8'h0D; prog_wdata = 16'h1234;
    #1;
    chk("prog_blocks_ready", {31'd0, req_ready}, 32'd0);
    tick;
    prog_we = 1'b0;

    // Read latency: accept at edge 0, response after edge 3
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h0D;
    tick;
    req_valid = 1'b0; req_addr = 8'hFF;
    chk("rd_busy_e0",   {31'd0, busy},      32'd1);
    chk("rd_ready_e0",  {31'd0, req_ready}, 32'd0);
    tick;
    chk("rd_valid_e1",  {31'd0, rsp_valid}, 32'd0);
    tick;
    chk("rd_valid_e2",  {31'd0, rsp_valid}, 32'd0);
    tick;
    chk("rd_valid_e3",  {31'd0, rsp_valid}, 32'd1);
    chk("rd_data_e3",   {16'd0, rsp_rdata}, 32'h1234);
    chk("rd_ready_e3",  {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rd_valid_done", {31'd0, rsp_valid}, 32'd0);
    chk("rd_busy_done",  {31'd0, busy},      32'd0);
    chk("rd_ready_done", {31'd0, req_ready}, 32'd1);

    // Write with backpressure on the response
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h20; req_wdata = 16'hBEEF;
    tick;
    req_valid = 1'b0; req_wdata = 16'h0000;
    tick; tick; tick;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data",  {16'd0, rsp_rdata}, 32'hBEEF);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    xact(1'b0, 8'h20, 16'h0, rd);
    chk("raw_0x20", {16'd0, rd}, 32'hBEEF);

    // CPU write commit collides with program write, same address
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h30; req_wdata = 16'h1111;
    tick;
    req_valid = 1'b0;
    tick; tick;
    prog_we = 1'b1; prog_addr = 8'h30; prog_wdata = 16'h2222;
    tick;
    prog_we = 1'b0;
    chk("coll_wr_valid", {31'd0, rsp_valid}, 32'd1);
    chk("coll_wr_echo",  {16'd0, rsp_rdata}, 32'h1111);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    xact(1'b0, 8'h30, 16'h0, rd);
    chk("coll_wr_array", {16'd0, rd}, 32'h2222);

    // CPU read commit collides with program write: old value returned
    prog(8'h50, 16'h0A0A);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h50;
    tick;
    req_valid = 1'b0;
    tick; tick;
    prog_we = 1'b1; prog_addr = 8'h50; prog_wdata = 16'h0B0B;
    tick;
    prog_we = 1'b0;
    chk("coll_rd_old", {16'd0, rsp_rdata}, 32'h0A0A);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    xact(1'b0, 8'h50, 16'h0, rd);
    chk("coll_rd_new", {16'd0, rd}, 32'h0B0B);

    // Reset during WAIT discards the uncommitted write
    prog(8'h40, 16'h0000);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h40; req_wdata = 16'h5555;
    tick;
    req_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_busy",  {31'd0, busy},      32'd0);
    tick;
    rst = 1'b0;
    xact(1'b0, 8'h40, 16'h0, rd);
    chk("arst_array", {16'd0, rd}, 32'h0000);

    // WAIT_CYCLES=0 back-to-back reads, 3 cycles per transaction
    prog_we0 = 1'b1; prog_addr0 = 8'h01; prog_wdata0 = 16'hAAAA;
    tick;
    prog_addr0 = 8'h02; prog_wdata0 = 16'hBBBB;
    tick;
    prog_we0 = 1'b0;
    req_valid0 = 1'b1; req_rw0 = 1'b0; req_addr0 = 8'h01; rsp_ready0 = 1'b1;
    tick;                                  // edge N: accept 0x01
    req_addr0 = 8'h02;
    chk("w0_busy_n",   {31'd0, busy0},      32'd1);
    chk("w0_valid_n",  {31'd0, rsp_valid0}, 32'd0);
    tick;                                  // edge N+1
    chk("w0_valid_n1", {31'd0, rsp_valid0}, 32'd1);
    chk("w0_data_n1",  {16'd0, rsp_rdata0}, 32'hAAAA);
    tick;                                  // edge N+2: handshake
    chk("w0_valid_n2", {31'd0, rsp_valid0}, 32'd0);
    chk("w0_ready_n2", {31'd0, req_ready0}, 32'd1);
    tick;                                  // edge N+3: accept 0x02
    chk("w0_valid_n3", {31'd0, rsp_valid0}, 32'd0);
    tick;                                  // edge N+4
    chk("w0_valid_n4", {31'd0, rsp_valid0}, 32'd1);
    chk("w0_data_n4",  {16'd0, rsp_rdata0}, 32'hBBBB);
    req_valid0 = 1'b0;
    tick;
    rsp_ready0 = 1'b0;
    chk("w0_idle", {31'd0, busy0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's memory access interface.
- Accepts single read/write requests through a valid/ready handshake, holds a 2**ADDR_W x DATA_W storage array, and returns each response after a programmable number of wait states through a second valid/ready handshake.
- A side program port lets a loader or testbench write the array at any time.
- Sits between the controller/datapath memory signals and storage, and gives the multicycle FSM a memory with real latency.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, wait states between request acceptance and response (legal range 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_rw  in  1  1 = write, 0 = read (same encoding as MemRW).
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  read data, or echoed write data for writes.
- prog_we  in  1  program-port write strobe.
- prog_addr  in  ADDR_W  program-port address.
- prog_wdata  in  DATA_W  program-port data.
- busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - Latched request is cleared. Array contents are not reset.
- req_ready is combinational: 1 only when state == IDLE and prog_we == 0. No handshake completes while rst is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with req_valid && req_ready, latch rw/addr/wdata, load counter = WAIT_CYCLES, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter == 0, the next edge goes to RESP and commits the access. Otherwise decrement the counter.
  - Commit for a read: rsp_rdata <= array[addr], sampled at that edge.
  - Commit for a write: array[addr] <= wdata and rsp_rdata <= wdata.
- RESP:
  - rsp_valid = 1; rsp_rdata is held stable.
  - On an edge with rsp_ready, go to IDLE and drop rsp_valid.
  - rsp_ready low holds RESP indefinitely.
- Latency: a request accepted at edge N raises rsp_valid after edge N+WAIT_CYCLES+1. Minimum period per transaction is WAIT_CYCLES+3 cycles.
- The latched request is immune to changes on req_* after acceptance.
- Program port:
  - prog_we writes array[prog_addr] <= prog_wdata at the edge, in any state.
  - It only blocks new acceptance; it does not stall an in-flight transaction.
- Collision at the same edge:
  - CPU write commit and prog_we to the same address: prog_wdata wins in the array, while rsp_rdata still echoes the CPU wdata.
  - Different addresses: both writes occur.
  - CPU read commit with prog_we to the same address: the read returns the old (pre-edge) value.
- Read after write: a read accepted after a write's RESP handshake returns the new data.
- Reset mid-operation:
  - An in-flight write that has not committed is discarded.
  - rsp_valid drops asynchronously.
  - A write already committed remains in the array.
- Address wrap is not applicable: every ADDR_W value is a valid location.

Test Plan (WAIT_CYCLES=2 unless noted):
- Reset release, no stimulus -> rsp_valid=0, rsp_rdata=0x0000, busy=0, req_ready=1.
- prog write 0x0D<=0x1234; read 0x0D accepted at edge 0 -> busy=1 after edge 0, rsp_valid=1 after edge 3 with rsp_rdata=0x1234, req_ready=0 until after the rsp handshake.
- Write 0x20<=0xBEEF, hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata=0xBEEF stable, req_ready=0; release, then read 0x20 -> 0xBEEF.
- CPU write 0x30<=0x1111 with prog_we 0x30<=0x2222 on the commit edge -> write response echoes 0x1111; subsequent read 0x30 returns 0x2222.
- prog 0x40<=0x0000; write 0x40<=0x5555, assert rst in WAIT before commit -> rsp_valid=0 and busy=0 immediately; read 0x40 after reset returns 0x0000.
- WAIT_CYCLES=0, req_valid and rsp_ready held 1, reads of 0x01, 0x02 preloaded 0xAAAA, 0xBBBB -> rsp_valid after edges N+1 and N+4 with data 0xAAAA then 0xBBBB (3 cycles per transaction).
